// File: rtl/line_burst_writer.sv
// Write-back serializer: captures one byte-masked cache line and drives it to
// physical memory as a fixed-length burst of beats, each with a byte strobe.
module line_burst_writer #(
  parameter int LINE_WIDTH = 256,
  parameter int BEAT_WIDTH = 64,
  parameter int BEATS      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_i,
  output logic                    ready_o,
  input  logic [LINE_WIDTH-1:0]   line_i,
  input  logic [LINE_WIDTH/8-1:0] mask_i,
  input  logic [31:0]             addr_i,
  output logic                    done_o,
  output logic                    pmem_write_o,
  output logic [31:0]             pmem_address_o,
  output logic [BEAT_WIDTH-1:0]   pmem_wdata_o,
  output logic [BEAT_WIDTH/8-1:0] pmem_strb_o,
  input  logic                    pmem_resp_i,
  output logic [1:0]              dbg_state
);

  localparam int MASK_W = LINE_WIDTH / 8;
  localparam int STRB_W = BEAT_WIDTH / 8;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_W  = $clog2(LINE_WIDTH / 8);

  // Handshakes: req_i is taken on a rising edge where ready_o=1 (ready_o does
  // not depend on req_i). Each beat is held until a rising edge with
  // pmem_resp_i=1; pmem_resp_i outside a burst has no effect.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt;
  logic [LINE_WIDTH-1:0] line_q;
  logic [MASK_W-1:0]   mask_q;
  logic [31:0]         addr_q;

  logic                accept;
  logic                last_beat;
  logic [BEAT_WIDTH-1:0] beat_data;
  logic [STRB_W-1:0]   beat_strb;

  assign accept    = (state == IDLE) && req_i;
  assign last_beat = (cnt == CNT_W'(BEATS - 1));
  assign dbg_state = state;

  // Beat selection as an explicit mux keeps the index arithmetic width-clean.
  always_comb begin
    beat_data = '0;
    beat_strb = '0;
    for (int b = 0; b < BEATS; b++) begin
      if (cnt == CNT_W'(b)) begin
        beat_data = line_q[b*BEAT_WIDTH +: BEAT_WIDTH];
        beat_strb = mask_q[b*STRB_W +: STRB_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      line_q <= '0;
      mask_q <= '0;
      addr_q <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        line_q <= line_i;
        mask_q <= mask_i;
        addr_q <= {addr_i[31:OFF_W], {OFF_W{1'b0}}};
        cnt    <= '0;
      end else if ((state == BURST) && pmem_resp_i) begin
        cnt <= last_beat ? '0 : cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_n        = state;
    ready_o        = 1'b0;
    done_o         = 1'b0;
    pmem_write_o   = 1'b0;
    pmem_address_o = '0;
    pmem_wdata_o   = '0;
    pmem_strb_o    = '0;
    case (state)
      IDLE: begin
        ready_o = 1'b1;
        if (req_i) begin
          // An all-zero mask has nothing to write, so skip memory entirely.
          state_n = (mask_i != '0) ? BURST : DONE;
        end
      end
      BURST: begin
        pmem_write_o   = 1'b1;
        pmem_address_o = addr_q;
        pmem_wdata_o   = beat_data;
        pmem_strb_o    = beat_strb;
        if (pmem_resp_i && last_beat) begin
          state_n = DONE;
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_line_burst_writer.sv
// Bench for line_burst_writer: directed and randomized line write-backs checked
// against a beat-by-beat reference computed from the line, mask and address.
module tb_line_burst_writer;

  logic         clk;
  logic         rst;
  logic         req_i;
  logic         ready_o;
  logic [255:0] line_i;
  logic [31:0]  mask_i;
  logic [31:0]  addr_i;
  logic         done_o;
  logic         pmem_write_o;
  logic [31:0]  pmem_address_o;
  logic [63:0]  pmem_wdata_o;
  logic [7:0]   pmem_strb_o;
  logic         pmem_resp_i;
  logic [1:0]   dbg_state;

  int tests_run = 0;
  int tests_failed = 0;

  line_burst_writer dut (
    .clk            (clk),
    .rst            (rst),
    .req_i          (req_i),
    .ready_o        (ready_o),
    .line_i         (line_i),
    .mask_i         (mask_i),
    .addr_i         (addr_i),
    .done_o         (done_o),
    .pmem_write_o   (pmem_write_o),
    .pmem_address_o (pmem_address_o),
    .pmem_wdata_o   (pmem_wdata_o),
    .pmem_strb_o    (pmem_strb_o),
    .pmem_resp_i    (pmem_resp_i),
    .dbg_state      (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    assert (got === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // One write-back. mode 0: resp every cycle, 1: fixed stall pattern,
  // 2: random resp. stray: raise a second request mid-burst.
  task automatic run_txn(input logic [255:0] line, input logic [31:0] mask,
                         input logic [31:0] addr, input int mode, input bit stray);
    int pat [8] = '{0, 0, 1, 0, 1, 1, 0, 1};
    logic [63:0] exp_w;
    logic [7:0]  exp_s;
    logic [31:0] exp_a;
    int k;
    int cyc;
    bit r;
    exp_a = addr & 32'hFFFF_FFE0;
    @(negedge clk);
    check("ready_before_accept", ready_o, 1'b1);
    req_i  = 1'b1;
    line_i = line;
    mask_i = mask;
    addr_i = addr;
    @(posedge clk);
    #1;
    req_i  = 1'b0;
    line_i = ~line;
    mask_i = ~mask;
    addr_i = ~addr;
    if (mask == 32'h0) begin
      @(negedge clk);
      check("empty_done", done_o, 1'b1);
      check("empty_write", pmem_write_o, 1'b0);
      check("empty_ready_low", ready_o, 1'b0);
      @(negedge clk);
      check("empty_ready_back", ready_o, 1'b1);
      check("empty_done_low", done_o, 1'b0);
      check("empty_write_idle", pmem_write_o, 1'b0);
      return;
    end
    k = 0;
    cyc = 0;
    while (k < 4) begin
      @(negedge clk);
      exp_w = 64'(line >> (64 * k));
      exp_s = 8'(mask >> (8 * k));
      check($sformatf("beat%0d_write", k), pmem_write_o, 1'b1);
      check($sformatf("beat%0d_wdata", k), pmem_wdata_o, exp_w);
      check($sformatf("beat%0d_strb", k), pmem_strb_o, exp_s);
      check($sformatf("beat%0d_addr", k), pmem_address_o, exp_a);
      check($sformatf("beat%0d_done_low", k), done_o, 1'b0);
      check($sformatf("beat%0d_ready_low", k), ready_o, 1'b0);
      if (stray && k == 1) begin
        req_i  = 1'b1;
        line_i = rand_line();
        mask_i = 32'hFFFF_FFFF;
        addr_i = 32'hDEAD_BEEF;
      end
      case (mode)
        0: r = 1'b1;
        1: r = (pat[cyc % 8] != 0);
        default: r = ($urandom_range(0, 2) != 0);
      endcase
      pmem_resp_i = r;
      @(posedge clk);
      if (r) k++;
      cyc++;
      if (cyc > 200) begin
        check("burst_timeout", 1'b1, 1'b0);
        break;
      end
    end
    @(negedge clk);
    pmem_resp_i = 1'b0;
    req_i = 1'b0;
    check("done_pulse", done_o, 1'b1);
    check("done_write_low", pmem_write_o, 1'b0);
    check("done_ready_low", ready_o, 1'b0);
    @(negedge clk);
    check("idle_ready", ready_o, 1'b1);
    check("idle_done_low", done_o, 1'b0);
    check("idle_no_burst", pmem_write_o, 1'b0);
    if (stray) begin
      @(negedge clk);
      check("stray_no_second_burst", pmem_write_o, 1'b0);
    end
  endtask

  initial begin
    logic [255:0] basic;
    logic [255:0] l2;
    rst = 1'b1;
    req_i = 1'b0;
    line_i = '0;
    mask_i = '0;
    addr_i = '0;
    pmem_resp_i = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_ready", ready_o, 1'b1);
    check("rst_done", done_o, 1'b0);
    check("rst_write", pmem_write_o, 1'b0);
    check("rst_addr", pmem_address_o, 32'h0);
    check("rst_wdata", pmem_wdata_o, 64'h0);
    check("rst_strb", pmem_strb_o, 8'h0);
    rst = 1'b0;

    // basic full-mask burst
    for (int k = 0; k < 4; k++) basic[k*64 +: 64] = 64'h1111_1111_1111_1111 * (k + 1);
    run_txn(basic, 32'hFFFF_FFFF, 32'h0000_1234, 0, 1'b0);

    // strobe slicing
    run_txn(basic, 32'h0F00_00F1, 32'h0000_4000, 0, 1'b0);

    // stall pattern
    run_txn(rand_line(), 32'hA5A5_5A5A, 32'h8000_003F, 1, 1'b0);

    // empty mask
    run_txn(rand_line(), 32'h0, 32'h0000_2000, 0, 1'b0);

    // stray resp while idle must not move anything
    @(negedge clk);
    pmem_resp_i = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("stray_resp_write", pmem_write_o, 1'b0);
      check("stray_resp_ready", ready_o, 1'b1);
    end
    pmem_resp_i = 1'b0;

    // busy: second request during burst is ignored
    run_txn(rand_line(), 32'h1234_F00F, 32'h0000_0040, 0, 1'b1);

    // reset mid-burst after beat 1 resp
    l2 = rand_line();
    @(negedge clk);
    req_i = 1'b1;
    line_i = l2;
    mask_i = 32'hFFFF_FFFF;
    addr_i = 32'h0000_3000;
    @(posedge clk);
    #1;
    req_i = 1'b0;
    pmem_resp_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    pmem_resp_i = 1'b0;
    @(negedge clk);
    check("pre_rst_wdata", pmem_wdata_o, l2[191:128]);
    rst = 1'b1;
    #1;
    check("midrst_write", pmem_write_o, 1'b0);
    check("midrst_ready", ready_o, 1'b1);
    check("midrst_done", done_o, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_no_done", done_o, 1'b0);
    end
    run_txn(l2, 32'hFFFF_FFFF, 32'h0000_3000, 0, 1'b0);

    // randomized write-backs
    for (int t = 0; t < 20; t++) begin
      logic [31:0] m;
      m = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
      if ($urandom_range(0, 3) == 0) m[15:8] = 8'h00;
      run_txn(rand_line(), m, $urandom, 2, 1'(t % 4 == 1));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
